// File: rtl/cmp_pkg.sv
// Shared encodings for the execute-stage comparator: result codes, requester IDs,
// and the response-register state encoding.
package cmp_pkg;

  localparam int unsigned CMP_W = 32;

  localparam logic [2:0] CMP_LT = 3'b001;
  localparam logic [2:0] CMP_EQ = 3'b010;
  localparam logic [2:0] CMP_GT = 3'b100;

  localparam int unsigned REQ_BR  = 0;
  localparam int unsigned REQ_ALU = 1;
  localparam int unsigned REQ_AMO = 2;

  typedef enum logic {
    CMP_EMPTY = 1'b0,
    CMP_FULL  = 1'b1
  } resp_state_e;

endpackage

// File: rtl/cmp_core.sv
// Core 32-bit comparator: one-hot lt/eq/gt, signed or unsigned.
module cmp_core
  import cmp_pkg::*;
(
  input  logic [CMP_W-1:0] s1,
  input  logic [CMP_W-1:0] s2,
  input  logic             is_unsigned,
  output logic [2:0]       result_c
);

  // Opposite sign bits decide a signed compare; otherwise the unsigned order holds.
  always_comb begin
    if (s1 == s2) begin
      result_c = CMP_EQ;
    end else if (!is_unsigned && (s1[CMP_W-1] != s2[CMP_W-1])) begin
      result_c = s1[CMP_W-1] ? CMP_LT : CMP_GT;
    end else begin
      result_c = (s1 < s2) ? CMP_LT : CMP_GT;
    end
  end

endmodule

// File: rtl/cmp_rr_arbiter.sv
// Grant selection: optional fixed priority for the branch unit, else round-robin
// from rr_ptr; the pointer only moves after an accepted round-robin grant.
module cmp_rr_arbiter
  import cmp_pkg::*;
#(
  parameter int N_REQ       = 3,
  parameter int BRANCH_PRIO = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic                     accept,
  output logic [N_REQ-1:0]         grant_c,
  output logic [$clog2(N_REQ)-1:0] grant_id_c
);

  localparam int unsigned IDW = $clog2(N_REQ);

  logic [IDW-1:0] rr_ptr_q;
  logic [IDW-1:0] rr_ptr_d;
  logic [IDW-1:0] idx_c;
  logic           prio_c;
  logic           found_c;

  always_comb begin
    grant_c    = '0;
    grant_id_c = '0;
    idx_c      = '0;
    found_c    = 1'b0;
    prio_c     = (BRANCH_PRIO != 0) && req_valid[REQ_BR];
    if (prio_c) begin
      grant_c[REQ_BR] = 1'b1;
      grant_id_c      = IDW'(REQ_BR);
    end else begin
      for (int k = 0; k < N_REQ; k++) begin
        idx_c = IDW'((int'(rr_ptr_q) + k) % N_REQ);
        if (!found_c && req_valid[idx_c]) begin
          found_c        = 1'b1;
          grant_c[idx_c] = 1'b1;
          grant_id_c     = idx_c;
        end
      end
    end
    rr_ptr_d = (int'(grant_id_c) == N_REQ - 1) ? '0 : grant_id_c + IDW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= '0;
    end else if (accept && !prio_c) begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/cmp_share_arb.sv
// Shares one comparator among N_REQ requesters; results land in a single-entry
// response register with backpressure and flush.
module cmp_share_arb
  import cmp_pkg::*;
#(
  parameter int N_REQ       = 3,
  parameter int BRANCH_PRIO = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [CMP_W*N_REQ-1:0]   req_s1,
  input  logic [CMP_W*N_REQ-1:0]   req_s2,
  input  logic [N_REQ-1:0]         req_unsigned,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [$clog2(N_REQ)-1:0] resp_id,
  output logic [2:0]               resp_result
);

  localparam int unsigned IDW = $clog2(N_REQ);

  resp_state_e      state_q;
  resp_state_e      state_d;
  logic [N_REQ-1:0] grant_c;
  logic [IDW-1:0]   grant_id_c;
  logic             can_accept_c;
  logic             hs_c;
  logic             load_c;
  logic [CMP_W-1:0] s1_c;
  logic [CMP_W-1:0] s2_c;
  logic             uns_c;
  logic [2:0]       result_c;

  cmp_rr_arbiter #(
    .N_REQ       (N_REQ),
    .BRANCH_PRIO (BRANCH_PRIO)
  ) u_arb (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .accept     (hs_c),
    .grant_c    (grant_c),
    .grant_id_c (grant_id_c)
  );

  assign resp_valid = (state_q == CMP_FULL);

  always_comb begin
    can_accept_c = !flush && (!resp_valid || resp_ready);
    req_ready    = can_accept_c ? grant_c : '0;
    hs_c         = |(req_valid & req_ready);
  end

  // AND-OR operand mux keyed by the one-hot grant, so operands never reach ready.
  always_comb begin
    s1_c  = '0;
    s2_c  = '0;
    uns_c = |(req_unsigned & grant_c);
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_c[i]) begin
        s1_c = s1_c | req_s1[i*CMP_W +: CMP_W];
        s2_c = s2_c | req_s2[i*CMP_W +: CMP_W];
      end
    end
  end

  cmp_core u_core (
    .s1          (s1_c),
    .s2          (s2_c),
    .is_unsigned (uns_c),
    .result_c    (result_c)
  );

  // Response register next state; flush overrides everything.
  always_comb begin
    state_d = state_q;
    load_c  = 1'b0;
    if (flush) begin
      state_d = CMP_EMPTY;
    end else if (hs_c) begin
      state_d = CMP_FULL;
      load_c  = 1'b1;
    end else if ((state_q == CMP_FULL) && resp_ready) begin
      state_d = CMP_EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= CMP_EMPTY;
      resp_id     <= '0;
      resp_result <= 3'b000;
    end else begin
      state_q <= state_d;
      if (load_c) begin
        resp_id     <= grant_id_c;
        resp_result <= result_c;
      end
    end
  end

endmodule

// File: tb/tb_cmp_share_arb.sv
// Directed + random bench for cmp_share_arb; one instance with branch priority,
// one pure round-robin, both checked against a scoreboard model.
module tb_cmp_share_arb;

  typedef struct packed {
    logic [1:0] id;
    logic [2:0] res;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [2:0]  req_valid;
  logic [95:0] req_s1;
  logic [95:0] req_s2;
  logic [2:0]  req_unsigned;
  logic        resp_ready;

  logic [2:0]  rdy  [2];
  logic        rv   [2];
  logic [1:0]  rid  [2];
  logic [2:0]  rres [2];

  exp_t        sb [2][$];
  logic [1:0]  rr_m [2];
  bit          hs_m [2];
  bit          prio_m [2];
  bit          full_m [2];
  logic [1:0]  gi_m [2];
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  cmp_share_arb #(.N_REQ(3), .BRANCH_PRIO(1)) dut_p (
    .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid), .req_ready(rdy[0]),
    .req_s1(req_s1), .req_s2(req_s2), .req_unsigned(req_unsigned),
    .resp_valid(rv[0]), .resp_ready(resp_ready), .resp_id(rid[0]), .resp_result(rres[0])
  );

  cmp_share_arb #(.N_REQ(3), .BRANCH_PRIO(0)) dut_r (
    .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid), .req_ready(rdy[1]),
    .req_s1(req_s1), .req_s2(req_s2), .req_unsigned(req_unsigned),
    .resp_valid(rv[1]), .resp_ready(resp_ready), .resp_id(rid[1]), .resp_result(rres[1])
  );

  function automatic logic [2:0] ref_cmp(input logic [31:0] a, input logic [31:0] b,
                                         input logic u);
    if (a == b) return 3'b010;
    if (u) return (a < b) ? 3'b001 : 3'b100;
    return ($signed(a) < $signed(b)) ? 3'b001 : 3'b100;
  endfunction

  function automatic logic [2:0] pred_grant(input bit bp, input logic [1:0] rr,
                                            input logic [2:0] v, output bit prio,
                                            output logic [1:0] gi);
    prio = bp && v[0];
    gi   = 2'd0;
    if (prio) return 3'b001;
    for (int k = 0; k < 3; k++) begin
      int i = (int'(rr) + k) % 3;
      if (v[i]) begin
        gi = 2'(i);
        return 3'(3'b001 << i);
      end
    end
    return 3'b000;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic u);
    req_s1[i*32 +: 32] = a;
    req_s2[i*32 +: 32] = b;
    req_unsigned[i]    = u;
  endtask

  task automatic chk_reset_outputs(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s resp_valid[%0d]", tag, k), 8'(rv[k]), 8'd0);
      chk($sformatf("%s resp_id[%0d]", tag, k), 8'(rid[k]), 8'd0);
      chk($sformatf("%s resp_result[%0d]", tag, k), 8'(rres[k]), 8'd0);
    end
  endtask

  // One clock: check ready just after the inputs settle, advance the model at
  // the edge, then check the response register.
  task automatic step(input string tag);
    logic [2:0] g;
    logic [2:0] exp_r;
    logic [1:0] gi;
    bit         prio;
    exp_t       e;
    #1;
    for (int k = 0; k < 2; k++) begin
      full_m[k] = (sb[k].size() != 0);
      g         = pred_grant(k == 0, rr_m[k], req_valid, prio, gi);
      exp_r     = (!flush && (!full_m[k] || resp_ready)) ? g : 3'b000;
      chk($sformatf("%s req_ready[%0d]", tag, k), 8'(rdy[k]), 8'(exp_r));
      hs_m[k]   = |exp_r;
      gi_m[k]   = gi;
      prio_m[k] = prio;
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (flush) begin
        sb[k].delete();
      end else begin
        if (full_m[k] && resp_ready) void'(sb[k].pop_front());
        if (hs_m[k]) begin
          e.id  = gi_m[k];
          e.res = ref_cmp(req_s1[int'(gi_m[k])*32 +: 32], req_s2[int'(gi_m[k])*32 +: 32],
                          req_unsigned[gi_m[k]]);
          sb[k].push_back(e);
          if (!prio_m[k]) rr_m[k] = (gi_m[k] == 2'd2) ? 2'd0 : gi_m[k] + 2'd1;
        end
      end
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s resp_valid[%0d]", tag, k), 8'(rv[k]), 8'(sb[k].size() != 0));
      if (sb[k].size() != 0) begin
        chk($sformatf("%s resp_id[%0d]", tag, k), 8'(rid[k]), 8'(sb[k][0].id));
        chk($sformatf("%s resp_result[%0d]", tag, k), 8'(rres[k]), 8'(sb[k][0].res));
      end
    end
    @(negedge clk);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      sb[k].delete();
      rr_m[k] = 2'd0;
    end
  endtask

  initial begin
    rst = 1'b1;
    model_reset();
    // Reset held with random inputs.
    for (int c = 0; c < 3; c++) begin
      flush        = 1'($urandom_range(0, 1));
      req_valid    = 3'($urandom_range(0, 7));
      req_s1       = {$urandom, $urandom, $urandom};
      req_s2       = {$urandom, $urandom, $urandom};
      req_unsigned = 3'($urandom_range(0, 7));
      resp_ready   = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk_reset_outputs("reset_hold");
    end
    flush      = 1'b0;
    req_valid  = 3'b000;
    resp_ready = 1'b1;
    rst        = 1'b0;
    step("idle");

    // Single ALU request, signed then unsigned.
    set_req(1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    req_valid = 3'b010;
    step("alu_signed");
    set_req(1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
    step("alu_unsigned");
    req_valid = 3'b000;
    step("drain1");

    // Arbitration with all three continuously valid.
    set_req(0, 32'd5, 32'd9, 1'b0);
    set_req(1, 32'd9, 32'd9, 1'b1);
    set_req(2, 32'hFFFF_FFF0, 32'd3, 1'b1);
    req_valid = 3'b111;
    for (int c = 0; c < 6; c++) step("arb_all");
    req_valid = 3'b110;
    for (int c = 0; c < 3; c++) step("arb_no_br");

    // Backpressure: hold FULL for three cycles with requests pending.
    req_valid = 3'b100;
    step("bp_fill");
    resp_ready = 1'b0;
    req_valid  = 3'b011;
    for (int c = 0; c < 3; c++) step("bp_hold");
    resp_ready = 1'b1;
    step("bp_release");
    step("bp_next");
    req_valid = 3'b000;
    step("drain2");

    // Flush with a held response and a pending AMO request.
    req_valid = 3'b001;
    step("fl_fill");
    req_valid = 3'b100;
    flush     = 1'b1;
    step("flush");
    flush     = 1'b0;
    req_valid = 3'b000;
    step("post_flush");
    req_valid = 3'b110;
    step("post_flush_rr");
    req_valid = 3'b000;
    step("drain3");

    // Equality and sign edges through the AMO requester.
    req_valid = 3'b100;
    set_req(2, 32'h8000_0000, 32'h8000_0000, 1'b0);
    step("amo_eq");
    set_req(2, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0);
    step("amo_signed");
    set_req(2, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1);
    step("amo_unsigned");
    req_valid = 3'b000;
    step("drain4");

    // Random traffic including withdrawals, stalls and flushes.
    for (int c = 0; c < 60; c++) begin
      for (int i = 0; i < 3; i++) begin
        set_req(i, ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom,
                ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom,
                1'($urandom_range(0, 1)));
      end
      req_valid  = 3'($urandom_range(0, 7));
      resp_ready = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 9) == 0);
      step("random");
    end
    flush      = 1'b0;
    resp_ready = 1'b0;

    // Reset mid-operation clears outputs without waiting for a clock.
    req_valid = 3'b111;
    step("pre_reset");
    rst = 1'b1;
    #1;
    chk_reset_outputs("async_reset");
    model_reset();
    @(negedge clk);
    rst        = 1'b0;
    resp_ready = 1'b1;
    step("after_reset");
    req_valid = 3'b110;
    step("after_reset_rr");
    req_valid = 3'b000;
    step("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cmp_share_arb.md
# cmp_share_arb

Shared-comparator arbiter for the execute stage. Multiplexes the single 32-bit signed/unsigned comparator between N_REQ requesters (0 = branch unit, 1 = ALU slt/sltu, 2 = AMO min/max) using valid/ready request handshakes. Each accepted compare returns one registered result tagged with the requester ID. A single-entry output register provides response backpressure, and a flush input discards in-flight work.

## Interface
- N_REQ, 3, number of requesters (≥2)
- BRANCH_PRIO, 1, 1: requester 0 has fixed priority over round-robin; 0: pure round-robin
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  pipeline flush: drop the held response and block acceptance this cycle
- req_valid  in  N_REQ  per-requester compare request
- req_ready  out  N_REQ  grant/accept strobe, at most one bit set
- req_s1  in  32*N_REQ  operand 1; slice i belongs to requester i
- req_s2  in  32*N_REQ  operand 2; slice i belongs to requester i
- req_unsigned  in  N_REQ  1: unsigned compare; 0: signed compare
- resp_valid  out  1  response register holds a result
- resp_ready  in  1  owner of resp_id consumes the response
- resp_id  out  $clog2(N_REQ)  requester that owns the response
- resp_result  out  3  one-hot result: 3'b001 s1<s2, 3'b010 equal, 3'b100 s1>s2

## Operation
- can_accept = !flush && (!resp_valid || resp_ready).
- Grant selection, combinational:
  - If BRANCH_PRIO=1 and req_valid[0]: grant 0.
  - Otherwise: first valid index at or after rr_ptr, searching cyclically.
- req_ready[i] = can_accept && grant[i]. A handshake occurs when req_valid[i] && req_ready[i].
- Requesters hold valid and operands stable until ready. Deasserting valid before ready is legal and only withdraws the request.
- Comparator inputs are muxed from the granted slice. Selected result:
  - req_unsigned[g] = 1: unsigned result.
  - req_unsigned[g] = 0: signed result. Operands with opposite sign bits resolve by the sign bit; equal sign bits fall through to the unsigned result.
- On handshake: resp_result, resp_id and resp_valid are registered.
- rr_ptr moves to (g+1) mod N_REQ after a round-robin grant. A priority grant to requester 0 under BRANCH_PRIO leaves rr_ptr unchanged.
- Response register state machine:
  - EMPTY (resp_valid=0), on handshake: go to FULL.
  - FULL, resp_ready=1 with a new handshake: stay FULL and load the new result (back-to-back).
  - FULL, resp_ready=1 with no handshake: go to EMPTY.
  - FULL, resp_ready=0: hold resp_result and resp_id stable; req_ready is all-zero.
  - flush=1 in any state: go to EMPTY. No handshake occurs. rr_ptr is unchanged.
- Reset values:
  - resp_valid = 0, resp_id = 0, resp_result = 3'b000, rr_ptr = 0.
  - req_ready is combinational and is 0 while resp_valid=0 with no req_valid.

## Timing
- Latency: handshake in cycle N, response visible in cycle N+1.
- Throughput: one compare per cycle while resp_ready=1.
- req_ready depends combinationally on req_valid, resp_ready and flush. There are no combinational paths from the operand inputs to any handshake output.
- Simultaneous events:
  - flush with resp_ready: flush wins; the held response is discarded, not delivered.
  - flush with req_valid: no accept.
  - Reset asserted mid-operation: outputs clear immediately (asynchronously). The first grant after reset release is round-robin from index 0, or index 0 via branch priority.
- rr_ptr wrap: N_REQ-1 → 0.

## Structure
- Shared package cmp_pkg holds:
  - CMP_LT/CMP_EQ/CMP_GT encodings (3'b001/3'b010/3'b100);
  - requester ID constants REQ_BR=0, REQ_ALU=1, REQ_AMO=2;
  - response state encoding CMP_EMPTY/CMP_FULL.
- Instantiate the existing core comparator module exactly once. Do not duplicate the compare logic.
- One sub-module, cmp_rr_arbiter, holds the priority plus round-robin grant and rr_ptr update (N_REQ, BRANCH_PRIO).

## Test plan
- Reset: hold rst with random inputs → resp_valid=0, resp_id=0, resp_result=3'b000; after release, first grant follows rr_ptr=0.
- Single request, ALU: s1=32'hFFFFFFFF, s2=32'h00000001.
  - Signed: req_ready[1]=1 same cycle; next cycle resp_valid=1, id=1, result=3'b001.
  - Same operands unsigned: result=3'b100.
- Arbitration with all three valid continuously, resp_ready=1:
  - BRANCH_PRIO=0: grants 0,1,2,0,1,2.
  - BRANCH_PRIO=1: grant 0 every cycle; after req_valid[0] drops, grants resume 0→1,2 from the unchanged rr_ptr.
- Backpressure: resp_ready=0 for 3 cycles with FULL → resp_result/resp_id stable, req_ready=0. On release, a pending request is accepted in the same cycle, and the next response follows without a bubble.
- Flush: FULL plus req_valid[2] plus flush in one cycle → next cycle resp_valid=0, no req_ready, rr_ptr unchanged.
- Equality and sign edges:
  - s1=s2=32'h80000000 signed → 3'b010.
  - s1=32'h7FFFFFFF, s2=32'h80000000: signed → 3'b100; unsigned → 3'b001.
  - resp_id is correct for the AMO requester in each case.
